// File: rtl/fft_operand_loader.sv
// Operand loader for the 8-bit butterfly: synchronises the board switches,
// debounces the step key, sequences manual entry of W, B and A from the data
// switches, and offers the finished operand set over a valid/ready handshake.
module fft_operand_loader #(
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [9:0]        sw_i,
  input  logic              ops_ready_i,
  output logic              ops_valid_o,
  output logic [DATA_W-1:0] twiddle_o,
  output logic [DATA_W-1:0] re_b_o,
  output logic [DATA_W-1:0] im_b_o,
  output logic [DATA_W-1:0] re_a_o,
  output logic [DATA_W-1:0] im_a_o,
  output logic [7:0]        led_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLdW   = 3'd1,
    StLdReb = 3'd2,
    StLdImb = 3'd3,
    StLdRea = 3'd4,
    StLdIma = 3'd5,
    StOffer = 3'd6
  } state_e;

  // ---------------------------------------------------------------------------
  // Switch synchroniser
  // ---------------------------------------------------------------------------
  logic [9:0] sync_q [SYNC_STAGES];
  logic [9:0] s_sw;
  logic       s_en;
  logic       s_step;
  logic [DATA_W-1:0] s_data;

  // Shift every switch bit through SYNC_STAGES flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= sw_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign s_sw   = sync_q[SYNC_STAGES-1];
  assign s_en   = s_sw[9];
  assign s_step = s_sw[8];
  assign s_data = s_sw[DATA_W-1:0];

  // ---------------------------------------------------------------------------
  // Step key debouncer
  // ---------------------------------------------------------------------------
  logic [CntW-1:0] db_cnt_q, db_cnt_d;
  logic            db_level_q, db_level_d;
  logic            step_q, step_d;

  // Count consecutive cycles the key disagrees with the accepted level; a rising
  // acceptance produces a one-cycle step pulse.
  always_comb begin
    db_cnt_d   = db_cnt_q;
    db_level_d = db_level_q;
    step_d     = 1'b0;
    if (s_step == db_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == CntMax) begin
      db_level_d = s_step;
      db_cnt_d   = '0;
      step_d     = s_step;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // Debouncer state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_cnt_q   <= '0;
      db_level_q <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      db_cnt_q   <= db_cnt_d;
      db_level_q <= db_level_d;
      step_q     <= step_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry FSM
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   ops_valid_q, ops_valid_d;
  logic   cap_w, cap_reb, cap_imb, cap_rea, cap_ima;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: dropping enable wins over both step and handshake.
  always_comb begin
    state_d = state_q;
    if (state_q == StIdle) begin
      if (s_en) state_d = StLdW;
    end else if (!s_en) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StLdW:   if (step_q) state_d = StLdReb;
        StLdReb: if (step_q) state_d = StLdImb;
        StLdImb: if (step_q) state_d = StLdRea;
        StLdRea: if (step_q) state_d = StLdIma;
        StLdIma: if (step_q) state_d = StOffer;
        StOffer: if (ops_valid_q && ops_ready_i) state_d = StLdW;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs: capture strobes per operand and the registered valid.
  always_comb begin
    cap_w       = 1'b0;
    cap_reb     = 1'b0;
    cap_imb     = 1'b0;
    cap_rea     = 1'b0;
    cap_ima     = 1'b0;
    if (s_en && step_q) begin
      case (state_q)
        StLdW:   cap_w   = 1'b1;
        StLdReb: cap_reb = 1'b1;
        StLdImb: cap_imb = 1'b1;
        StLdRea: cap_rea = 1'b1;
        StLdIma: cap_ima = 1'b1;
        default: ;
      endcase
    end
    // Valid is high exactly while the registered state is OFFER.
    ops_valid_d = (state_d == StOffer);
  end

  // ---------------------------------------------------------------------------
  // Operand registers
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] twiddle_q, re_b_q, im_b_q, re_a_q, im_a_q;

  // Each operand changes only on its own capture strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      twiddle_q   <= '0;
      re_b_q      <= '0;
      im_b_q      <= '0;
      re_a_q      <= '0;
      im_a_q      <= '0;
      ops_valid_q <= 1'b0;
    end else begin
      if (cap_w)   twiddle_q <= s_data;
      if (cap_reb) re_b_q    <= s_data;
      if (cap_imb) im_b_q    <= s_data;
      if (cap_rea) re_a_q    <= s_data;
      if (cap_ima) im_a_q    <= s_data;
      ops_valid_q <= ops_valid_d;
    end
  end

  assign ops_valid_o = ops_valid_q;
  assign twiddle_o   = twiddle_q;
  assign re_b_o      = re_b_q;
  assign im_b_o      = im_b_q;
  assign re_a_o      = re_a_q;
  assign im_a_o      = im_a_q;
  assign led_o       = {5'b0, state_q};

endmodule
